// File: rtl/seq_det_pkg.sv
// Elaboration-time helpers for the parametrised serial pattern detector:
// KMP border length, KMP next-state step and state-register width.
package seq_det_pkg;

    localparam int MAX_N = 16;

    function automatic int state_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of it.
    // Pattern bit j (j = 0 is the first bit received) lives at pattern[n-1-j].
    function automatic int border_len(input logic [MAX_N-1:0] pattern, input int n);
        int  best;
        bit  ok;
        best = 0;
        for (int k = 1; k < MAX_N; k++) begin
            if (k < n) begin
                ok = 1'b1;
                for (int j = 0; j < MAX_N; j++) begin
                    if (j < k && pattern[n-1-j] != pattern[k-1-j]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    // Appends bit b to the s-bit matched prefix and returns the longest pattern
    // prefix that is a suffix of the result; a return value of n is a full match.
    function automatic int next_state(input logic [MAX_N-1:0] pattern, input int n,
                                      input int s, input logic b);
        int   best;
        int   idx;
        bit   ok;
        logic seq_bit;
        best = 0;
        for (int k = 1; k <= MAX_N; k++) begin
            if (k <= s + 1 && k <= n) begin
                ok = 1'b1;
                for (int j = 0; j < MAX_N; j++) begin
                    if (j < k) begin
                        idx     = s + 1 - k + j;
                        seq_bit = (idx == s) ? b : pattern[n-1-idx];
                        if (seq_bit != pattern[n-1-j]) ok = 1'b0;
                    end
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: never wraps, sticks at all-ones until cleared or reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector: KMP state machine whose transition table is fully
// resolved at elaboration, with Mealy/Moore output and a saturating match count.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int           N       = 5,
    parameter logic [N-1:0] PATTERN = 5'b11011,
    parameter bit           OVERLAP = 1'b0,
    parameter bit           MOORE   = 1'b0,
    parameter int           CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             signal,
    output logic             out,
    output logic [CNT_W-1:0] match_count
);

    localparam int               SW        = state_width(N);
    localparam logic [MAX_N-1:0] PAT16     = MAX_N'(PATTERN);
    localparam int               B         = border_len(PAT16, N);
    localparam int               AFTER_INT = OVERLAP ? B : 0;
    localparam logic [SW-1:0]    S_MATCH   = SW'(N);
    localparam logic [SW-1:0]    S_LAST    = SW'(N - 1);
    localparam logic [SW-1:0]    S_AFTER   = SW'(AFTER_INT);

    logic [SW-1:0] r_state;
    logic [SW-1:0] w_state_next;
    logic [SW-1:0] w_target;
    logic          w_match;
    logic          w_inc;
    logic [SW-1:0] w_trans [0:N][0:1];

    // Row N is the Moore match state; it leaves exactly as the post-match state does.
    for (genvar gi = 0; gi <= N; gi++) begin : g_state
        for (genvar gb = 0; gb < 2; gb++) begin : g_bit
            localparam int BASE = (gi == N) ? AFTER_INT : gi;
            localparam int TGT  = next_state(PAT16, N, BASE, 1'(gb));
            assign w_trans[gi][gb] = SW'(TGT);
        end
    end

    assign w_target = (r_state <= S_MATCH) ? w_trans[r_state][signal] : '0;
    assign w_match  = en && (w_target == S_MATCH);
    assign w_inc    = w_match && !clr;

    always_comb begin
        w_state_next = r_state;
        if (en) begin
            if (w_target == S_MATCH) begin
                w_state_next = MOORE ? S_MATCH : S_AFTER;
            end else begin
                w_state_next = w_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= '0;
        end else if (clr) begin
            r_state <= '0;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign out = MOORE ? (r_state == S_MATCH)
                       : (rst && en && (r_state == S_LAST) && (signal == PATTERN[0]));

    sat_counter #(
        .W (CNT_W)
    ) u_sat_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (w_inc),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: five detector configurations share one stimulus stream;
// each phase checks the instance(s) it targets against hand-computed values.
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic rst, en, clr, signal;

    logic       o0, o1, o2, o3, o4;
    logic [7:0] c0, c1, c2, c4;
    logic [1:0] c3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // d0: defaults (11011, Mealy, non-overlap)
    seq_detector_param u_d0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .signal(signal),
        .out(o0), .match_count(c0));

    // d1: 11011, Mealy, overlapping
    seq_detector_param #(.OVERLAP(1'b1)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .signal(signal),
        .out(o1), .match_count(c1));

    // d2: 1111, Moore, overlapping
    seq_detector_param #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .MOORE(1'b1)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .signal(signal),
        .out(o2), .match_count(c2));

    // d3: 10, Mealy, 2-bit counter
    seq_detector_param #(.N(2), .PATTERN(2'b10), .CNT_W(2)) u_d3 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .signal(signal),
        .out(o3), .match_count(c3));

    // d4: 11011, Moore, non-overlap
    seq_detector_param #(.MOORE(1'b1)) u_d4 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .signal(signal),
        .out(o4), .match_count(c4));

    task automatic chk(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    // Drive one cycle's inputs at the falling edge; sampling happens 1ns later,
    // i.e. Mealy out for these inputs and registered state from earlier edges.
    task automatic step(input logic en_v, input logic clr_v, input logic sig_v);
        @(negedge clk);
        en     = en_v;
        clr    = clr_v;
        signal = sig_v;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b0; clr = 1'b0; signal = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] stream_a;
        logic [7:0] exp_d0;
        logic [7:0] exp_d1;

        rst = 1'b0; en = 1'b1; clr = 1'b0; signal = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out_d0", int'(o0), 0);
        chk("reset_out_d1", int'(o1), 0);
        chk("reset_out_d2", int'(o2), 0);
        chk("reset_out_d4", int'(o4), 0);
        chk("reset_cnt_d0", int'(c0), 0);
        chk("reset_cnt_d3", int'(c3), 0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Phase A: 1,1,0,1,1,0,1,1 on 11011 non-overlap (d0) and overlap (d1)
        stream_a = 8'b11011011;
        exp_d0   = 8'b00001000;
        exp_d1   = 8'b00001001;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, stream_a[7-i]);
            chk($sformatf("A_out_d0_bit%0d", i + 1), int'(o0), int'(exp_d0[7-i]));
            chk($sformatf("A_out_d1_bit%0d", i + 1), int'(o1), int'(exp_d1[7-i]));
            if (i == 5) chk("A_cnt_d0_after_bit5", int'(c0), 1);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("A_cnt_d0_final", int'(c0), 1);
        chk("A_cnt_d1_final", int'(c1), 2);

        // Phase B1: Moore 1111 overlap, seven 1s -> out after bits 4..7
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 1'b0, 1'b1);
            chk($sformatf("B1_out_d2_step%0d", i), int'(o2), (i >= 5) ? 1 : 0);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("B1_out_d2_after_bit7", int'(o2), 1);
        chk("B1_cnt_d2", int'(c2), 4);

        // Phase B2: hold en=0 for 3 cycles after bit 4
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk($sformatf("B2_hold_out_d2_%0d", i), int'(o2), 1);
            chk($sformatf("B2_hold_cnt_d2_%0d", i), int'(c2), 1);
        end
        step(1'b1, 1'b0, 1'b1);
        chk("B2_out_d2_bit5", int'(o2), 1);
        step(1'b0, 1'b0, 1'b0);
        chk("B2_out_d2_after5", int'(o2), 1);
        chk("B2_cnt_d2_after5", int'(c2), 2);

        // Phase C: pattern 10 with 2-bit counter -> 1,2,3,3,3
        do_reset();
        for (int p = 0; p < 5; p++) begin
            step(1'b1, 1'b0, 1'b1);
            if (p > 0) chk($sformatf("C_cnt_d3_pair%0d", p), int'(c3), (p > 3) ? 3 : p);
            step(1'b1, 1'b0, 1'b0);
            chk($sformatf("C_out_d3_pair%0d", p + 1), int'(o3), 1);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("C_cnt_d3_pair5", int'(c3), 3);

        // Phase D1: 1,1,0,1 then reset pulse, then 1 -> prefix discarded, s=1
        do_reset();
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0; en = 1'b1; signal = 1'b1;
        #1;
        chk("D1_out_d0_in_reset", int'(o0), 0);
        @(negedge clk);
        rst = 1'b1; en = 1'b0;
        step(1'b1, 1'b0, 1'b1);
        chk("D1_out_d0_first1", int'(o0), 0);
        chk("D1_out_d4_first1", int'(o4), 0);
        step(1'b1, 1'b0, 1'b1);
        chk("D1_out_d0_b2", int'(o0), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("D1_out_d0_b3", int'(o0), 0);
        step(1'b1, 1'b0, 1'b1);
        chk("D1_out_d0_b4", int'(o0), 0);
        step(1'b1, 1'b0, 1'b1);
        chk("D1_out_d0_b5_match", int'(o0), 1);
        step(1'b0, 1'b0, 1'b0);
        chk("D1_cnt_d0", int'(c0), 1);

        // Phase D2: clr on the completing bit -> no Moore out, no increment
        do_reset();
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("D2_out_d4_after_clr", int'(o4), 0);
        chk("D2_cnt_d4_after_clr", int'(c4), 0);
        chk("D2_cnt_d0_after_clr", int'(c0), 0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("D2_out_d4_premature", int'(o4), 0);
        step(1'b0, 1'b0, 1'b0);
        chk("D2_out_d4_match", int'(o4), 1);
        chk("D2_cnt_d4_match", int'(c4), 1);

        // Phase E: en toggling mid-pattern on d0 -> exactly one match
        do_reset();
        step(1'b1, 1'b0, 1'b1);
        chk("E_out_d0_b1", int'(o0), 0);
        step(1'b1, 1'b0, 1'b1);
        chk("E_out_d0_b2", int'(o0), 0);
        step(1'b0, 1'b0, 1'b0);
        chk("E_out_d0_gap1", int'(o0), 0);
        step(1'b0, 1'b0, 1'b0);
        chk("E_out_d0_gap2", int'(o0), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("E_out_d0_b3", int'(o0), 0);
        step(1'b1, 1'b0, 1'b1);
        chk("E_out_d0_b4", int'(o0), 0);
        step(1'b1, 1'b0, 1'b1);
        chk("E_out_d0_b5", int'(o0), 1);
        step(1'b0, 1'b0, 1'b0);
        chk("E_cnt_d0", int'(c0), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
